// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types, constants and travel-cost rules for the hall-call dispatcher
// Contents: DIR_UP/DIR_DOWN, FSM state encoding, abs_diff and travel_cost helpers.
// The helpers work on 5-bit floors (up to 16 floors) and return a 6-bit cost;
// callers zero-extend their floors and truncate the cost to their own width.
package elevator_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_ASSIGN = 2'd2
  } state_t;

  function automatic logic [5:0] abs_diff(input logic [4:0] a, input logic [4:0] b);
    return (a > b) ? {1'b0, a - b} : {1'b0, b - a};
  endfunction

  // Idle lifts and lifts already heading through the call floor in the call's
  // direction pay only the direct distance; any other lift first finishes its
  // current trip and then travels back to the call.
  function automatic logic [5:0] travel_cost(input logic [4:0] curr, input logic [4:0] dest,
                                             input logic [4:0] req, input logic req_dir);
    logic lift_up;
    logic on_way;
    lift_up = (dest > curr);
    on_way  = (lift_up == req_dir) &&
              (lift_up ? (req >= curr && req <= dest) : (req <= curr && req >= dest));
    if (curr == dest || on_way)
      return abs_diff(curr, req);
    return abs_diff(curr, dest) + abs_diff(dest, req);
  endfunction

endpackage

// File: rtl/elevator_cost.sv
// rtl/elevator_cost.sv - combinational travel cost of one lift for one hall call
// Ports: curr/dest - lift current and destination floor; req_floor/req_dir - the call;
//        cost - FLOOR_W+1 bit travel cost (cannot overflow: max is 2*(floors-1)).
module elevator_cost
  import elevator_pkg::*;
#(
  parameter int FLOOR_W = 3
) (
  input  logic [FLOOR_W-1:0] curr,
  input  logic [FLOOR_W-1:0] dest,
  input  logic [FLOOR_W-1:0] req_floor,
  input  logic               req_dir,
  output logic [FLOOR_W:0]   cost
);

  assign cost = (FLOOR_W+1)'(travel_cost(5'(curr), 5'(dest), 5'(req_floor), req_dir));

endmodule

// File: rtl/elevator_dispatcher.sv
// rtl/elevator_dispatcher.sv - N-lift hall-call dispatcher with round-robin call service
// Ports: clk/reset (sync, active-high); req_valid/req_floor/req_dir - hall call input;
//        curr_floor/dest_floor - packed lift positions, lift i at [i*FLOOR_W +: FLOOR_W];
//        asg_valid/asg_ready/asg_lift/asg_floor/asg_dir - assignment handshake;
//        hall_pending - lamp bitmap, bit floor*2+dir.
// Optional: ELEVATOR_LIFT_MASK_EN adds lift_enable[N_LIFTS]; disabled lifts are skipped.
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter int N_LIFTS  = 2,
  parameter int N_FLOORS = 8,
  parameter int FLOOR_W  = $clog2(N_FLOORS),
  parameter int LIFT_W   = (N_LIFTS > 2) ? $clog2(N_LIFTS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  input  logic [FLOOR_W-1:0]         req_floor,
  input  logic                       req_dir,
  input  logic [N_LIFTS*FLOOR_W-1:0] curr_floor,
  input  logic [N_LIFTS*FLOOR_W-1:0] dest_floor,
`ifdef ELEVATOR_LIFT_MASK_EN
  input  logic [N_LIFTS-1:0]         lift_enable,
`endif
  output logic                       asg_valid,
  input  logic                       asg_ready,
  output logic [LIFT_W-1:0]          asg_lift,
  output logic [FLOOR_W-1:0]         asg_floor,
  output logic                       asg_dir,
  output logic [2*N_FLOORS-1:0]      hall_pending
);

  localparam int N_CALLS = 2 * N_FLOORS;
  localparam int PTR_W   = $clog2(N_CALLS);
  localparam int TOP_I   = N_FLOORS - 1;
  localparam int LAST_L  = N_LIFTS - 1;
  localparam int LAST_C  = N_CALLS - 1;
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = TOP_I[FLOOR_W-1:0];
  localparam logic [LIFT_W-1:0]  LAST_LIFT = LAST_L[LIFT_W-1:0];
  localparam logic [PTR_W-1:0]   LAST_CALL = LAST_C[PTR_W-1:0];
  localparam logic [N_CALLS-1:0] CALL_BIT0 = 1;

  state_t              state;
  logic [PTR_W-1:0]    scan_ptr;
  logic [PTR_W-1:0]    call_idx;
  logic [LIFT_W-1:0]   lift_cnt;
  logic [LIFT_W-1:0]   best_lift;
  logic [FLOOR_W:0]    best_cost;
  logic [FLOOR_W:0]    cost;

  // Request legality: the top floor has no up button, floor 0 no down button.
  logic floor_in_range;
  if ((1 << FLOOR_W) > N_FLOORS) begin : g_range
    localparam logic [FLOOR_W-1:0] FLOOR_LIMIT = N_FLOORS[FLOOR_W-1:0];
    assign floor_in_range = (req_floor < FLOOR_LIMIT);
  end else begin : g_full
    assign floor_in_range = 1'b1;
  end

  logic               req_legal;
  logic               handshake;
  logic [N_CALLS-1:0] set_mask;
  logic [N_CALLS-1:0] clr_mask;

  always_comb begin
    req_legal = req_valid && floor_in_range &&
                !(req_dir == DIR_UP && req_floor == TOP_FLOOR) &&
                !(req_dir == DIR_DOWN && req_floor == '0);
    set_mask  = req_legal ? (CALL_BIT0 << {req_floor, req_dir}) : '0;
    handshake = asg_valid && asg_ready;
    clr_mask  = handshake ? (CALL_BIT0 << call_idx) : '0;
  end

  // Round-robin pick: first pending call at or after scan_ptr, wrapping.
  logic             pick_found;
  logic [PTR_W-1:0] pick_idx;
  int               scan_j;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_j     = 0;
    for (int i = 0; i < N_CALLS; i++) begin
      scan_j = int'(scan_ptr) + i;
      if (scan_j >= N_CALLS)
        scan_j = scan_j - N_CALLS;
      if (!pick_found && hall_pending[scan_j]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(scan_j);
      end
    end
  end

  logic [PTR_W-1:0] next_ptr;
  assign next_ptr = (call_idx == LAST_CALL) ? '0 : call_idx + PTR_W'(1);

  // One cost unit, time-shared across lifts by the lift counter.
  logic [FLOOR_W-1:0] eval_curr;
  logic [FLOOR_W-1:0] eval_dest;
  assign eval_curr = curr_floor[lift_cnt*FLOOR_W +: FLOOR_W];
  assign eval_dest = dest_floor[lift_cnt*FLOOR_W +: FLOOR_W];

  elevator_cost #(.FLOOR_W(FLOOR_W)) u_cost (
    .curr     (eval_curr),
    .dest     (eval_dest),
    .req_floor(call_idx[PTR_W-1:1]),
    .req_dir  (call_idx[0]),
    .cost     (cost)
  );

  logic lift_en;
  logic do_assign;
`ifdef ELEVATOR_LIFT_MASK_EN
  logic any_en;
  assign lift_en   = lift_enable[lift_cnt];
  assign do_assign = any_en || lift_en;
`else
  assign lift_en   = 1'b1;
  assign do_assign = 1'b1;
`endif

  // best_cost starts at all-ones, above any real cost, so the first eligible
  // lift always wins; strict compare keeps ties on the lowest index.
  logic              better;
  logic [LIFT_W-1:0] final_lift;
  assign better     = lift_en && (cost < best_cost);
  assign final_lift = better ? lift_cnt : best_lift;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      scan_ptr     <= '0;
      call_idx     <= '0;
      lift_cnt     <= '0;
      best_lift    <= '0;
      best_cost    <= '0;
      asg_valid    <= 1'b0;
      asg_lift     <= '0;
      asg_floor    <= '0;
      asg_dir      <= 1'b0;
      hall_pending <= '0;
`ifdef ELEVATOR_LIFT_MASK_EN
      any_en       <= 1'b0;
`endif
    end else begin
      // A call arriving in the clearing cycle keeps its bit set.
      hall_pending <= (hall_pending & ~clr_mask) | set_mask;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            call_idx  <= pick_idx;
            best_cost <= '1;
            best_lift <= '0;
            lift_cnt  <= '0;
`ifdef ELEVATOR_LIFT_MASK_EN
            any_en    <= 1'b0;
`endif
            state     <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (better) begin
            best_cost <= cost;
            best_lift <= lift_cnt;
          end
`ifdef ELEVATOR_LIFT_MASK_EN
          any_en <= any_en || lift_en;
`endif
          if (lift_cnt == LAST_LIFT) begin
            if (do_assign) begin
              asg_valid <= 1'b1;
              asg_lift  <= final_lift;
              asg_floor <= call_idx[PTR_W-1:1];
              asg_dir   <= call_idx[0];
              state     <= ST_ASSIGN;
            end else begin
              // No eligible lift: leave the call lit, move on to the next one.
              scan_ptr <= next_ptr;
              state    <= ST_IDLE;
            end
          end else begin
            lift_cnt <= lift_cnt + LIFT_W'(1);
          end
        end
        ST_ASSIGN: begin
          if (asg_ready) begin
            asg_valid <= 1'b0;
            scan_ptr  <= next_ptr;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_dispatcher.sv
// tb/tb_elevator_dispatcher.sv - self-checking bench for elevator_dispatcher
module tb_elevator_dispatcher;

  localparam int N_LIFTS  = 2;
  localparam int N_FLOORS = 8;
  localparam int FW       = 3;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic [FW-1:0] req_floor;
  logic          req_dir;
  logic [N_LIFTS*FW-1:0] curr_floor;
  logic [N_LIFTS*FW-1:0] dest_floor;
  logic          asg_valid;
  logic          asg_ready;
  logic          asg_lift;
  logic [FW-1:0] asg_floor;
  logic          asg_dir;
  logic [2*N_FLOORS-1:0] hall_pending;

  elevator_dispatcher #(.N_LIFTS(N_LIFTS), .N_FLOORS(N_FLOORS)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_floor   (req_floor),
    .req_dir     (req_dir),
    .curr_floor  (curr_floor),
    .dest_floor  (dest_floor),
`ifdef ELEVATOR_LIFT_MASK_EN
    .lift_enable ('1),
`endif
    .asg_valid   (asg_valid),
    .asg_ready   (asg_ready),
    .asg_lift    (asg_lift),
    .asg_floor   (asg_floor),
    .asg_dir     (asg_dir),
    .hall_pending(hall_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int c0, d0, c1, d1;
    int floor, dir;
    int exp_lift;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lifts(input int c0, input int d0, input int c1, input int d1);
    curr_floor = {3'(c1), 3'(c0)};
    dest_floor = {3'(d1), 3'(d0)};
  endtask

  task automatic send_call(input int floor, input int dir);
    req_valid = 1'b1;
    req_floor = 3'(floor);
    req_dir   = 1'(dir);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!asg_valid && cycles < 20) begin
      step();
      cycles++;
    end
  endtask

  task automatic consume();
    asg_ready = 1'b1;
    step();
    asg_ready = 1'b0;
  endtask

  int  cyc;
  bit  stable, any_valid, any_pend;
  int  snap_lift, snap_floor, snap_dir;

  initial begin
    // L0 curr/dest, L1 curr/dest, call floor/dir, expected lift (costs in parentheses)
    vecs[0] = '{5, 2, 7, 6, 3, 0, 0};  // 2 vs 4
    vecs[1] = '{5, 0, 1, 2, 3, 1, 1};  // 8 vs 2
    vecs[2] = '{2, 2, 4, 4, 3, 1, 0};  // tie 1 vs 1
    vecs[3] = '{0, 7, 6, 6, 6, 0, 1};  // 8 vs 0
    vecs[4] = '{7, 7, 0, 7, 4, 1, 0};  // 3 vs 4 (on the way)
    vecs[5] = '{0, 0, 6, 7, 7, 0, 1};  // 7 vs 1 (top floor down)
    vecs[6] = '{3, 3, 1, 5, 0, 1, 0};  // 3 vs 9 (floor 0 up)

    reset = 1'b1; req_valid = 1'b0; req_floor = '0; req_dir = 1'b0;
    asg_ready = 1'b0; curr_floor = '0; dest_floor = '0;
    step();
    step();
    check("reset_asg_valid", int'(asg_valid), 0);
    check("reset_asg_lift", int'(asg_lift), 0);
    check("reset_asg_floor", int'(asg_floor), 0);
    check("reset_asg_dir", int'(asg_dir), 0);
    check("reset_pending", int'(hall_pending), 0);
    reset = 1'b0;
    step();

    for (int v = 0; v < 7; v++) begin
      set_lifts(vecs[v].c0, vecs[v].d0, vecs[v].c1, vecs[v].d1);
      send_call(vecs[v].floor, vecs[v].dir);
      check($sformatf("v%0d_pending_set", v), int'(hall_pending[vecs[v].floor*2+vecs[v].dir]), 1);
      wait_valid(cyc);
      check($sformatf("v%0d_latency", v), cyc, 3);
      check($sformatf("v%0d_lift", v), int'(asg_lift), vecs[v].exp_lift);
      check($sformatf("v%0d_floor", v), int'(asg_floor), vecs[v].floor);
      check($sformatf("v%0d_dir", v), int'(asg_dir), vecs[v].dir);
      consume();
      check($sformatf("v%0d_valid_drop", v), int'(asg_valid), 0);
      check($sformatf("v%0d_pending_clr", v), int'(hall_pending), 0);
    end

    // Illegal calls are dropped
    send_call(7, 1);
    send_call(0, 0);
    any_valid = 0; any_pend = 0;
    for (int i = 0; i < 8; i++) begin
      if (asg_valid) any_valid = 1;
      if (hall_pending != 0) any_pend = 1;
      step();
    end
    check("illegal_pending", int'(any_pend), 0);
    check("illegal_valid", int'(any_valid), 0);

    // Two calls with a stalled consumer
    set_lifts(2, 2, 6, 6);
    send_call(3, 1);
    send_call(5, 0);
    check("stall_pending_both", int'(hall_pending), (1 << 7) | (1 << 10));
    wait_valid(cyc);
    check("stall_first_valid", int'(asg_valid), 1);
    check("stall_first_lift", int'(asg_lift), 0);
    check("stall_first_floor", int'(asg_floor), 3);
    check("stall_first_dir", int'(asg_dir), 1);
    snap_lift = int'(asg_lift); snap_floor = int'(asg_floor); snap_dir = int'(asg_dir);
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!asg_valid || int'(asg_lift) != snap_lift || int'(asg_floor) != snap_floor ||
          int'(asg_dir) != snap_dir)
        stable = 0;
    end
    check("stall_stable", int'(stable), 1);
    consume();
    check("stall_pending_after1", int'(hall_pending), 1 << 10);
    wait_valid(cyc);
    check("stall_second_lift", int'(asg_lift), 1);
    check("stall_second_floor", int'(asg_floor), 5);
    check("stall_second_dir", int'(asg_dir), 0);
    consume();
    check("stall_pending_after2", int'(hall_pending), 0);

    // Same call re-raised in the clearing cycle keeps its bit
    set_lifts(0, 0, 7, 7);
    send_call(4, 1);
    wait_valid(cyc);
    asg_ready = 1'b1; req_valid = 1'b1; req_floor = 3'd4; req_dir = 1'b1;
    step();
    asg_ready = 1'b0; req_valid = 1'b0;
    check("rearm_pending_kept", int'(hall_pending[9]), 1);
    check("rearm_valid_drop", int'(asg_valid), 0);
    wait_valid(cyc);
    check("rearm_floor", int'(asg_floor), 4);
    check("rearm_lift", int'(asg_lift), 1);
    consume();
    check("rearm_pending_clr", int'(hall_pending), 0);

    // Reset while an assignment is held and another call is pending
    set_lifts(2, 2, 6, 6);
    send_call(3, 1);
    wait_valid(cyc);
    send_call(5, 0);
    check("rst_pre_valid", int'(asg_valid), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_valid", int'(asg_valid), 0);
    check("rst_pending", int'(hall_pending), 0);
    set_lifts(2, 2, 5, 5);
    send_call(4, 1);
    wait_valid(cyc);
    check("rst_new_latency", cyc, 3);
    check("rst_new_lift", int'(asg_lift), 1);
    check("rst_new_floor", int'(asg_floor), 4);
    consume();
    check("rst_new_pending", int'(hall_pending), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_dispatcher.md
Name: elevator_dispatcher

Overview:
- Sequential N-lift hall-call dispatcher; successor to the fixed two-lift, eight-floor elevator_controller.
- Latches hall calls into a pending bitmap and serves them round-robin.
- For each call, evaluates lifts one per cycle with a travel-cost function and issues a valid/ready assignment to the lift sequencing logic.

Parameters:
- N_LIFTS, 2, number of lifts (2..8).
- N_FLOORS, 8, number of floors (2..16).
- FLOOR_W, $clog2(N_FLOORS), floor index width.
- LIFT_W, (N_LIFTS>2)?$clog2(N_LIFTS):1, lift index width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  hall call present.
- req_floor  in  FLOOR_W  calling floor.
- req_dir  in  1  1=up, 0=down.
- curr_floor  in  N_LIFTS*FLOOR_W  packed current floors; lift i in [i*FLOOR_W +: FLOOR_W].
- dest_floor  in  N_LIFTS*FLOOR_W  packed destination floors, same packing.
- asg_valid  out  1  assignment available.
- asg_ready  in  1  assignment consumed.
- asg_lift  out  LIFT_W  selected lift.
- asg_floor  out  FLOOR_W  floor served.
- asg_dir  out  1  direction served.
- hall_pending  out  2*N_FLOORS  pending bitmap for hall lamps; bit index = floor*2+dir.

Behaviour:
- Reset: all registers clear; asg_valid=0, asg_lift=0, asg_floor=0, asg_dir=0, hall_pending=0, scan pointer=0, FSM=IDLE. Reset mid-operation discards any held assignment and all pending calls; asg_valid is low the cycle after reset is asserted.
- Request capture:
  - req_valid is sampled every cycle; no ready signal.
  - A call sets hall_pending[floor*2+dir] on the next edge.
  - Already-set bit: no-op.
  - Illegal calls (floor N_FLOORS-1 up, floor 0 down, floor >= N_FLOORS) are dropped silently.
- IDLE:
  - If hall_pending != 0, select the first set bit at or after the scan pointer, rotating with wrap. Latch its index.
  - Init best_cost = all-ones, best_lift = 0, lift counter = 0. Go to EVAL.
- EVAL: one lift per cycle, index k = lift counter.
  - Idle (curr==dest): cost = |curr-req|.
  - On the way: lift dir (up if dest>curr) == req_dir, and req lies between curr and dest inclusive. cost = |curr-req|.
  - Otherwise: cost = |curr-dest| + |dest-req|.
  - Cost width FLOOR_W+1; no overflow is possible.
  - Strictly lower cost replaces best, so ties go to the lowest index.
  - After lift N_LIFTS-1 is evaluated, go to ASSIGN.
  - Lift inputs are sampled only in the cycle their lift is evaluated.
- ASSIGN:
  - asg_valid=1 with asg_lift/floor/dir registered and held stable until asg_ready.
  - On asg_valid&&asg_ready: clear the served pending bit, scan pointer = index+1 (wrap at 2*N_FLOORS), go to IDLE.
  - A new request for the same floor/dir in the clearing cycle wins: the bit stays set.
- Latency: pending bit visible in IDLE to asg_valid = N_LIFTS+1 cycles. Minimum cycle per assignment = N_LIFTS+2.

Optional Feature:
- Macro: ELEVATOR_LIFT_MASK_EN.
- With the macro defined:
  - Adds input lift_enable [N_LIFTS].
  - Disabled lifts are skipped in EVAL; they are still counted in the cycle count.
  - If no lift is enabled at the end of EVAL: return to IDLE with no assignment, pending bit kept, scan pointer advanced past the call.
- Without the macro: the port is absent and all lifts are eligible.

Decomposition:
- Package elevator_pkg holds:
  - DIR_UP=1, DIR_DOWN=0.
  - FSM state encoding: IDLE=0, EVAL=1, ASSIGN=2.
  - Cost function, ported from the controller's cost rules.
- One sub-module, elevator_cost: combinational cost of one lift given curr, dest, req_floor, req_dir. Instantiated once and muxed by the lift counter.

Test Plan:
- L0 5->2, L1 7->6, call floor 3 down -> costs 2/4; asg_lift=0, asg_floor=3, asg_dir=0, 3 cycles after pending.
- L0 5->0, L1 1->2, call floor 3 up -> costs 8/2; asg_lift=1.
- L0 idle at 2, L1 idle at 4, call floor 3 up -> tie at cost 1; asg_lift=0.
- Calls floor 7 up and floor 0 down -> dropped; hall_pending stays 0, no asg_valid.
- Calls 3-up and 5-down with asg_ready low, then asg_ready high -> served 3-up then 5-down; asg fields stable while stalled; hall_pending bits clear in order.
- Reset asserted while asg_valid=1 -> next cycle asg_valid=0 and hall_pending=0; a new call then serves normally.
